// File: rtl/fb_loader_pkg.sv
// Shared types and constants for the ioctl framebuffer loader.
// Holds the loader FSM states, CRC-16/CCITT-FALSE constants and the parameter check.
package fb_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_FLUSH     = 2'd2,
    ST_WAIT_SWAP = 2'd3
  } fb_state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  function automatic bit bpp_valid(input int bpp);
    return (bpp >= 1) && (bpp <= 4);
  endfunction

endpackage

// File: rtl/crc16_ccitt_byte.sv
// Byte-wide CRC-16/CCITT next-state, MSB first; purely combinational, no backpressure.
// Only present in builds with FB_LOADER_CRC_EN, the sole configuration that uses it.
`ifdef FB_LOADER_CRC_EN
module crc16_ccitt_byte
  import fb_loader_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  always_comb begin
    crc_out = crc_in ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[15] ? ((crc_out << 1) ^ CRC_POLY) : (crc_out << 1);
    end
  end

endmodule
`endif

// File: rtl/ioctl_fb_loader.sv
// Packs hps_io download bytes into pixels and writes them to a (double-buffered) framebuffer.
// Latency: fb_we one cycle after the completing ioctl_wr; accepts one byte per cycle, no backpressure.
// Optional CRC-16 over accepted bytes when FB_LOADER_CRC_EN is defined; otherwise crc reads 0.
module ioctl_fb_loader
  import fb_loader_pkg::*;
#(
  parameter int BYTES_PER_PIX = 1,
  parameter int ADDR_W        = 16,
  parameter int NUM_PIX       = 64000,
  parameter int DOUBLE_BUF    = 1
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic                       ioctl_download,
  input  logic                       ioctl_wr,
  input  logic [26:0]                ioctl_addr,
  input  logic [7:0]                 ioctl_dout,
  input  logic                       vblank,
  output logic                       fb_we,
  output logic [ADDR_W:0]            fb_addr,
  output logic [8*BYTES_PER_PIX-1:0] fb_data,
  output logic                       disp_bank,
  output logic                       progress,
  output logic                       done,
  output logic [ADDR_W:0]            pix_count,
  output logic                       overflow,
  output logic                       err_addr,
  output logic [15:0]                crc
);

  localparam int PIX_W = 8 * BYTES_PER_PIX;
  localparam logic [ADDR_W:0] NUM_PIX_C = (ADDR_W + 1)'(NUM_PIX);
  localparam logic [1:0] LANE_LAST = 2'(BYTES_PER_PIX - 1);

  if (!bpp_valid(BYTES_PER_PIX) || (NUM_PIX > (1 << ADDR_W))) begin : g_param_err
    $error("ioctl_fb_loader: BYTES_PER_PIX must be 1..4 and NUM_PIX <= 2**ADDR_W");
  end

  fb_state_e         state, state_nxt;
  logic              dl_q, vb_q;
  logic [26:0]       byte_cnt;
  logic [1:0]        lane, lane_after;
  logic [PIX_W-1:0]  pix_buf, pix_word;
  logic              load_bank;
  logic              dl_rise, dl_fall, vb_rise;
  logic              wr_ok, wr_bad, pix_full, room;
  logic              start, swap, done_go;

  assign dl_rise  = ioctl_download & ~dl_q;
  assign dl_fall  = ~ioctl_download & dl_q;
  assign vb_rise  = vblank & ~vb_q;
  assign wr_ok    = (state == ST_LOAD) && ioctl_wr && (ioctl_addr == byte_cnt);
  assign wr_bad   = (state == ST_LOAD) && ioctl_wr && (ioctl_addr != byte_cnt);
  assign pix_full = wr_ok && (lane == LANE_LAST);
  assign room     = (pix_count < NUM_PIX_C);
  assign progress = (state != ST_IDLE);

  // Lane after this cycle's byte: the fall decision must see a byte accepted alongside it.
  assign lane_after = pix_full ? 2'd0 : (wr_ok ? lane + 2'd1 : lane);

  always_comb begin
    pix_word = pix_buf;
    for (int l = 0; l < BYTES_PER_PIX; l++) begin
      if (lane == 2'(l)) pix_word[8*l +: 8] = ioctl_dout;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    swap      = 1'b0;
    done_go   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dl_rise) begin
          start     = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (dl_fall) begin
          if (lane_after != 2'd0) begin
            state_nxt = ST_FLUSH;
          end else begin
            state_nxt = (DOUBLE_BUF != 0) ? ST_WAIT_SWAP : ST_IDLE;
            done_go   = (DOUBLE_BUF == 0);
          end
        end
      end
      ST_FLUSH: begin
        state_nxt = (DOUBLE_BUF != 0) ? ST_WAIT_SWAP : ST_IDLE;
        done_go   = (DOUBLE_BUF == 0);
      end
      ST_WAIT_SWAP: begin
        // A fresh download wins over a coincident vblank and reloads the same back bank.
        if (dl_rise) begin
          start     = 1'b1;
          state_nxt = ST_LOAD;
        end else if (vb_rise) begin
          swap      = 1'b1;
          done_go   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      dl_q      <= 1'b0;
      vb_q      <= 1'b0;
      byte_cnt  <= '0;
      lane      <= '0;
      pix_buf   <= '0;
      load_bank <= 1'b0;
      disp_bank <= 1'b0;
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_data   <= '0;
      done      <= 1'b0;
      pix_count <= '0;
      overflow  <= 1'b0;
      err_addr  <= 1'b0;
    end else begin
      state <= state_nxt;
      dl_q  <= ioctl_download;
      vb_q  <= vblank;
      fb_we <= 1'b0;
      done  <= done_go;
      if (swap) disp_bank <= ~disp_bank;
      if (start) begin
        byte_cnt  <= '0;
        lane      <= '0;
        pix_buf   <= '0;
        pix_count <= '0;
        overflow  <= 1'b0;
        err_addr  <= 1'b0;
        load_bank <= (DOUBLE_BUF != 0) ? ~disp_bank : disp_bank;
      end else begin
        if (wr_bad) err_addr <= 1'b1;
        if (wr_ok) begin
          byte_cnt <= byte_cnt + 27'd1;
          lane     <= lane_after;
          if (pix_full) begin
            pix_buf <= '0;
            if (room) begin
              fb_we     <= 1'b1;
              fb_addr   <= {load_bank, pix_count[ADDR_W-1:0]};
              fb_data   <= pix_word;
              pix_count <= pix_count + 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end else begin
            pix_buf <= pix_word;
          end
        end
        // Unfilled lanes of pix_buf are still zero from the last pixel boundary.
        if (state == ST_FLUSH) begin
          lane    <= '0;
          pix_buf <= '0;
          if (room) begin
            fb_we     <= 1'b1;
            fb_addr   <= {load_bank, pix_count[ADDR_W-1:0]};
            fb_data   <= pix_buf;
            pix_count <= pix_count + 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end
      end
    end
  end

`ifdef FB_LOADER_CRC_EN
  logic [15:0] crc_q, crc_nxt;

  crc16_ccitt_byte u_crc (
    .crc_in  (crc_q),
    .data    (ioctl_dout),
    .crc_out (crc_nxt)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= '0;
    end else if (start) begin
      crc_q <= CRC_INIT;
    end else if (wr_ok) begin
      crc_q <= crc_nxt;
    end
  end

  assign crc = crc_q;
`else
  assign crc = 16'h0000;
`endif

endmodule

// File: doc/ioctl_fb_loader.md
# ioctl_fb_loader

Parametrised image loader between `hps_io` ioctl download and a video framebuffer RAM. Packs the HPS byte stream into `8*BYTES_PER_PIX`-bit pixels and writes one pixel per RAM write into a back bank, with address checking, overflow detection and partial-pixel flush. With `DOUBLE_BUF`, it swaps banks on the next vertical blank so scanout never shows a half-loaded image. It replaces the fixed 8-bit, single-buffer ROM copy path in the lesson cores.

## Interface
- `BYTES_PER_PIX`, default 1: bytes per pixel, range 1..4.
- `ADDR_W`, default 16: pixel address width per bank.
- `NUM_PIX`, default 64000: pixels per bank; must be ≤ 2^ADDR_W.
- `DOUBLE_BUF`, default 1: 1 gives two banks with a vblank swap; 0 gives a single bank.
- `clk_sys`, in, 1: sole clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `ioctl_download`, `ioctl_wr`, in, 1 each: from `hps_io`.
- `ioctl_addr`, in, 27: byte address from `hps_io`.
- `ioctl_dout`, in, 8: download byte.
- `vblank`, in, 1: synchronous to `clk_sys`.
- `fb_we`, out, 1: framebuffer write strobe.
- `fb_addr`, out, ADDR_W+1: `{bank, pixel index}`.
- `fb_data`, out, 8*BYTES_PER_PIX: pixel data.
- `disp_bank`, out, 1: bank for scanout to read.
- `progress`, out, 1: high while the FSM is not in IDLE; drives `LED_USER`.
- `done`, out, 1: one-cycle pulse when a load completes.
- `pix_count`, out, ADDR_W+1: pixels written in the current or last load.
- `overflow`, out, 1: sticky; set when pixels beyond `NUM_PIX` are dropped.
- `err_addr`, out, 1: sticky; set when `ioctl_addr` does not match the expected byte count.
- `crc`, out, 16: see Configuration.

## Operation
- FSM states: IDLE, LOAD, FLUSH, WAIT_SWAP.
- IDLE → LOAD on the rising edge of `ioctl_download` (registered edge detect). On entry:
  - clear the byte counter, lane, `pix_count`, `overflow`, `err_addr` and CRC;
  - set `load_bank` = `~disp_bank` when `DOUBLE_BUF`=1, else `disp_bank`.
- LOAD, per `ioctl_wr`:
  - If `ioctl_addr` ≠ byte counter: set `err_addr` and discard the byte; the counter does not advance.
  - Otherwise store the byte in lane L at bits [8L+7:8L] (little-endian), increment the counter and advance the lane.
  - When lane `BYTES_PER_PIX-1` fills and `pix_count` < `NUM_PIX`: write the pixel, increment `pix_count`, reset the lane to 0.
  - When lane `BYTES_PER_PIX-1` fills and `pix_count` = `NUM_PIX`: drop the pixel and set `overflow`.
- LOAD → FLUSH on the falling edge of `ioctl_download` if lane ≠ 0. FLUSH writes the partial pixel with its unfilled lanes zeroed, obeying the same `NUM_PIX` limit.
- LOAD or FLUSH completion:
  - `DOUBLE_BUF`=1: go to WAIT_SWAP.
  - `DOUBLE_BUF`=0: pulse `done` and go to IDLE.
- WAIT_SWAP: on a `vblank` rising edge, toggle `disp_bank`, pulse `done` and go to IDLE.
- A new `ioctl_download` rise while in WAIT_SWAP cancels the swap and re-enters LOAD into the same back bank. `disp_bank` is unchanged and no `done` pulse is produced.
- An `ioctl_wr` in the same cycle as the `ioctl_download` fall is accepted before the fall is processed.
- `ioctl_wr` while in IDLE or WAIT_SWAP is ignored.
- Outputs after reset: every output is 0, `disp_bank`=0, state IDLE. Reset mid-load abandons the load with no flush.

## Timing
- `fb_we` is high for exactly one cycle, on the cycle after the `ioctl_wr` that completes a pixel. `fb_addr` and `fb_data` are registered and valid only while `fb_we` is high.
- Sustains one `ioctl_wr` per cycle without loss.
- FLUSH writes one cycle after the fall is detected; it occupies one state cycle.
- `disp_bank` toggles and `done` pulses on the clock edge after the cycle in which `vblank`=1 with previous `vblank`=0.
- `err_addr` and `overflow` update one cycle after the offending `ioctl_wr`.

## Configuration
- `FB_LOADER_CRC_EN` defined: CRC-16/CCITT-FALSE (polynomial 0x1021, init 0xFFFF) runs over every accepted byte, including dropped overflow bytes. It updates one cycle after each accepted byte and holds after the load.
- `FB_LOADER_CRC_EN` undefined: `crc` is tied to 16'h0000 and no CRC logic is built.

## Structure
- Package `fb_loader_pkg` holds:
  - the state enum;
  - `CRC_POLY` and `CRC_INIT` constants;
  - the `BYTES_PER_PIX` range check function.
- One sub-module, `crc16_ccitt_byte`: combinational, byte-wide CRC next-state. It is instantiated only under `FB_LOADER_CRC_EN`.

## Test plan
- **Two-byte pixels.** `BYTES_PER_PIX`=2; bytes 0x34, 0x12, 0x78, 0x56 at addresses 0..3; download falls; `vblank` rises.
  - Writes: `{1,0}`=0x1234, then `{1,1}`=0x5678.
  - Then `disp_bank`=1, one `done` pulse, `pix_count`=2.
- **Partial-pixel flush.** `BYTES_PER_PIX`=3; bytes 0x11, 0x22, 0x33, 0x44; download falls.
  - Writes: pixel 0 = 0x332211, then flushed pixel 1 = 0x000044.
- **Overflow.** `NUM_PIX`=4, `BYTES_PER_PIX`=1; 6 bytes sent.
  - Exactly 4 writes, `overflow`=1, `pix_count`=4.
- **Address gap.** Addresses 0, 1, 3 presented.
  - `err_addr`=1; byte at address 3 is not written; `pix_count`=2.
- **Swap cancel, then reset.**
  - New download during WAIT_SWAP: `disp_bank` stays 0, and the reload again writes bank 1.
  - `reset_n` pulsed low mid-LOAD: all outputs read 0 immediately; the next load targets bank 1.
- **CRC.** ASCII "123456789" loaded.
  - With `FB_LOADER_CRC_EN`: `crc`=0x29B1.
  - Without it: `crc`=0x0000.
